// File: rtl/ex_mem_pipe_pkg.sv
// rtl/ex_mem_pipe_pkg.sv - shared types and default widths for the EX/MEM pipeline register
package ex_mem_pipe_pkg;

    // Default widths: RegBus, MEMAddrBus, register-file address width
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MEM_ADDR_W = 32;
    localparam int DEF_REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_RSV = 2'd3
    } mem_size_e;

    typedef struct packed {
        logic                      mem_re;
        logic                      mem_we;
        mem_size_e                 mem_size;
        logic [DEF_MEM_ADDR_W-1:0] mem_addr;
        logic [DEF_DATA_W-1:0]     mem_wdata;
        logic                      regfile_re;
        logic                      regfile_we;
        logic [DEF_REG_ADDR_W-1:0] regfile_waddr;
        logic [DEF_DATA_W-1:0]     alu_result;
    } ex_mem_payload_t;

    // Flattened payload width for arbitrary parameter choices
    function automatic int payload_w(input int data_w, input int addr_w, input int reg_w);
        return 2 + 2 + addr_w + data_w + 2 + reg_w + data_w;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_if.sv
// rtl/ex_mem_pipe_if.sv - EX-side and MEM-side signal bundle of the EX/MEM pipeline register
//   slave  : view used by the pipeline register (consumes ex_*, mem_ready; drives the rest)
//   master : view used by the surrounding stages
interface ex_mem_pipe_if #(
    parameter int DATA_W     = ex_mem_pipe_pkg::DEF_DATA_W,
    parameter int MEM_ADDR_W = ex_mem_pipe_pkg::DEF_MEM_ADDR_W,
    parameter int REG_ADDR_W = ex_mem_pipe_pkg::DEF_REG_ADDR_W
);
    logic                  ex_valid;
    logic                  ex_ready;
    logic                  ex_mem_re;
    logic                  ex_mem_we;
    logic [1:0]            ex_mem_size;
    logic [MEM_ADDR_W-1:0] ex_mem_addr;
    logic [DATA_W-1:0]     ex_mem_wdata;
    logic                  ex_regfile_re;
    logic                  ex_regfile_we;
    logic [REG_ADDR_W-1:0] ex_regfile_waddr;
    logic [DATA_W-1:0]     ex_alu_result;

    logic                  mem_valid;
    logic                  mem_ready;
    logic                  mem_mem_re;
    logic                  mem_mem_we;
    logic [1:0]            mem_mem_size;
    logic [MEM_ADDR_W-1:0] mem_mem_addr;
    logic [DATA_W-1:0]     mem_mem_wdata;
    logic                  mem_regfile_re;
    logic                  mem_regfile_we;
    logic [REG_ADDR_W-1:0] mem_regfile_waddr;
    logic [DATA_W-1:0]     mem_data;

    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_waddr;
    logic [DATA_W-1:0]     fwd_data;

    logic                  err_rw;

    modport slave (
        input  ex_valid, ex_mem_re, ex_mem_we, ex_mem_size, ex_mem_addr, ex_mem_wdata,
               ex_regfile_re, ex_regfile_we, ex_regfile_waddr, ex_alu_result, mem_ready,
        output ex_ready, mem_valid, mem_mem_re, mem_mem_we, mem_mem_size, mem_mem_addr,
               mem_mem_wdata, mem_regfile_re, mem_regfile_we, mem_regfile_waddr, mem_data,
               fwd_valid, fwd_waddr, fwd_data, err_rw
    );

    modport master (
        output ex_valid, ex_mem_re, ex_mem_we, ex_mem_size, ex_mem_addr, ex_mem_wdata,
               ex_regfile_re, ex_regfile_we, ex_regfile_waddr, ex_alu_result, mem_ready,
        input  ex_ready, mem_valid, mem_mem_re, mem_mem_we, mem_mem_size, mem_mem_addr,
               mem_mem_wdata, mem_regfile_re, mem_regfile_we, mem_regfile_waddr, mem_data,
               fwd_valid, fwd_waddr, fwd_data, err_rw
    );

endinterface

// File: rtl/ex_mem_pipe_skid.sv
// rtl/ex_mem_pipe_skid.sv - pipe_skid_reg: generic two-entry valid/ready skid register with flush
//   s_t* : upstream stream (s_tready is registered, equals !skid_valid)
//   m_t* : downstream stream, m_tdata always shows the main register
module pipe_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         s_tvalid,
    output logic         s_tready,
    input  logic [W-1:0] s_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic [W-1:0] m_tdata
);

    logic         main_valid;
    logic         skid_valid;
    logic [W-1:0] main_data;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         drain;

    // skid_valid is itself a flop, so ready never sees mem-side ready combinationally
    assign s_tready = !skid_valid;
    assign accept   = s_tvalid && s_tready;
    assign drain    = main_valid && m_tready;
    assign m_tvalid = main_valid;
    assign m_tdata  = main_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid && drain) begin
            // older skid entry moves up; upstream is stalled so nothing is accepted
            main_data  <= skid_data;
            skid_valid <= 1'b0;
        end else if (!main_valid || drain) begin
            main_data  <= s_tdata;
            main_valid <= accept;
        end else if (accept) begin
            // main is blocked: park the younger entry in the skid slot
            skid_data  <= s_tdata;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - EX->MEM pipeline register with skid buffer, flush, qualification, forwarding tap and conflict flag
//   clk, rst (async active-low), flush (sync), bus : ex_* / mem_* / fwd_* / err_rw signals
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_ADDR_W = DEF_MEM_ADDR_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    ex_mem_pipe_if.slave  bus
);

    localparam int PW = payload_w(DATA_W, MEM_ADDR_W, REG_ADDR_W);

    logic [PW-1:0]         in_data;
    logic [PW-1:0]         out_data;
    logic                  out_valid;
    logic                  in_ready;

    logic                  st_mem_re;
    logic                  st_mem_we;
    logic [1:0]            st_mem_size;
    logic [MEM_ADDR_W-1:0] st_mem_addr;
    logic [DATA_W-1:0]     st_mem_wdata;
    logic                  st_rf_re;
    logic                  st_rf_we;
    logic [REG_ADDR_W-1:0] st_rf_waddr;
    logic [DATA_W-1:0]     st_alu;

    logic                  err_q;

    assign in_data = {bus.ex_mem_re, bus.ex_mem_we, bus.ex_mem_size, bus.ex_mem_addr,
                      bus.ex_mem_wdata, bus.ex_regfile_re, bus.ex_regfile_we,
                      bus.ex_regfile_waddr, bus.ex_alu_result};

    pipe_skid_reg #(.W(PW)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .s_tvalid (bus.ex_valid),
        .s_tready (in_ready),
        .s_tdata  (in_data),
        .m_tvalid (out_valid),
        .m_tready (bus.mem_ready),
        .m_tdata  (out_data)
    );

    assign {st_mem_re, st_mem_we, st_mem_size, st_mem_addr, st_mem_wdata,
            st_rf_re, st_rf_we, st_rf_waddr, st_alu} = out_data;

    assign bus.ex_ready          = in_ready;
    assign bus.mem_valid         = out_valid;

    // Control bits are qualified so a stale payload can never trigger an access
    assign bus.mem_mem_re        = st_mem_re & out_valid;
    assign bus.mem_mem_we        = st_mem_we & out_valid;
    assign bus.mem_regfile_re    = st_rf_re & out_valid;
    assign bus.mem_regfile_we    = st_rf_we & out_valid;

    assign bus.mem_mem_size      = st_mem_size;
    assign bus.mem_mem_addr      = st_mem_addr;
    assign bus.mem_mem_wdata     = st_mem_wdata;
    assign bus.mem_regfile_waddr = st_rf_waddr;
    assign bus.mem_data          = st_alu;

    // Loads are not forwarded: their value is not known until the memory returns it
    assign bus.fwd_valid = out_valid && st_rf_we && !st_rf_re && (st_rf_waddr != '0);
    assign bus.fwd_waddr = st_rf_waddr;
    assign bus.fwd_data  = st_alu;

    // Sticky; flush deliberately leaves it alone
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (bus.ex_valid && in_ready && bus.ex_mem_re && bus.ex_mem_we) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_rw = err_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb/tb_ex_mem_pipe.sv - directed self-checking bench for ex_mem_pipe
module tb_ex_mem_pipe;

    logic clk;
    logic rst;
    logic flush;

    int n_assert;
    int n_fail;

    ex_mem_pipe_if #(.DATA_W(32), .MEM_ADDR_W(32), .REG_ADDR_W(5)) bus ();

    ex_mem_pipe #(.DATA_W(32), .MEM_ADDR_W(32), .REG_ADDR_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic mre, input logic mwe,
                         input logic [1:0] sz, input logic rre, input logic rwe, input logic [4:0] wa);
        bus.ex_valid         = v;
        bus.ex_alu_result    = alu;
        bus.ex_mem_addr      = alu + 32'h1000;
        bus.ex_mem_wdata     = ~alu;
        bus.ex_mem_re        = mre;
        bus.ex_mem_we        = mwe;
        bus.ex_mem_size      = sz;
        bus.ex_regfile_re    = rre;
        bus.ex_regfile_we    = rwe;
        bus.ex_regfile_waddr = wa;
    endtask

    task automatic send(input logic [31:0] alu);
        drive(1'b1, alu, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b0;
        flush    = 1'b0;
        bus.mem_ready = 1'b1;
        idle();

        // reset state
        step();
        step();
        chk("rst_mem_valid", bus.mem_valid, 0);
        chk("rst_ex_ready", bus.ex_ready, 1);
        chk("rst_mem_data", bus.mem_data, 0);
        chk("rst_err_rw", bus.err_rw, 0);
        chk("rst_fwd_valid", bus.fwd_valid, 0);
        rst = 1'b1;
        step();
        chk("post_rst_mem_valid", bus.mem_valid, 0);

        // streaming 0x11..0x44
        for (int i = 1; i <= 4; i++) begin
            send(32'h11 * i);
            step();
            chk("stream_valid", bus.mem_valid, 1);
            chk("stream_data", bus.mem_data, 32'h11 * i);
            chk("stream_addr", bus.mem_mem_addr, 32'h11 * i + 32'h1000);
            chk("stream_ready", bus.ex_ready, 1);
        end
        idle();
        step();
        chk("stream_end_valid", bus.mem_valid, 0);

        // back-pressure
        bus.mem_ready = 1'b0;
        send(32'hA1);
        step();
        chk("bp_a1_data", bus.mem_data, 32'hA1);
        chk("bp_a1_ready", bus.ex_ready, 1);
        send(32'hA2);
        step();
        chk("bp_a2_held_data", bus.mem_data, 32'hA1);
        chk("bp_a2_ready", bus.ex_ready, 0);
        send(32'hA3);
        step();
        chk("bp_a3_held_data", bus.mem_data, 32'hA1);
        chk("bp_a3_ready", bus.ex_ready, 0);
        bus.mem_ready = 1'b1;
        step();
        chk("bp_out2_valid", bus.mem_valid, 1);
        chk("bp_out2_data", bus.mem_data, 32'hA2);
        chk("bp_out2_ready", bus.ex_ready, 1);
        step();
        chk("bp_out3_valid", bus.mem_valid, 1);
        chk("bp_out3_data", bus.mem_data, 32'hA3);
        idle();
        step();
        chk("bp_end_valid", bus.mem_valid, 0);

        // flush with a skid entry pending
        bus.mem_ready = 1'b0;
        drive(1'b1, 32'hB1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 5'd0);
        step();
        chk("fl_b1_we", bus.mem_mem_we, 1);
        drive(1'b1, 32'hB2, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 5'd0);
        step();
        chk("fl_skid_ready", bus.ex_ready, 0);
        drive(1'b1, 32'hB3, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 5'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_mem_valid", bus.mem_valid, 0);
        chk("fl_ex_ready", bus.ex_ready, 1);
        chk("fl_mem_we", bus.mem_mem_we, 0);
        bus.mem_ready = 1'b1;
        send(32'h55);
        step();
        chk("fl_55_valid", bus.mem_valid, 1);
        chk("fl_55_data", bus.mem_data, 32'h55);
        // flush discards a simultaneous accept
        send(32'h66);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_accept_drop", bus.mem_valid, 0);
        idle();
        step();

        // forwarding tap
        drive(1'b1, 32'hDEAD, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd5);
        step();
        chk("fwd_valid", bus.fwd_valid, 1);
        chk("fwd_waddr", bus.fwd_waddr, 5);
        chk("fwd_data", bus.fwd_data, 32'hDEAD);
        chk("fwd_rf_we", bus.mem_regfile_we, 1);
        drive(1'b1, 32'hDEAD, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 5'd5);
        step();
        chk("fwd_load_valid", bus.fwd_valid, 0);
        chk("fwd_load_rf_re", bus.mem_regfile_re, 1);
        drive(1'b1, 32'hDEAD, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd0);
        step();
        chk("fwd_r0_valid", bus.fwd_valid, 0);
        idle();
        step();
        chk("fwd_idle_rf_we", bus.mem_regfile_we, 0);

        // read/write conflict, reserved size passes through
        drive(1'b1, 32'h77, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 5'd0);
        step();
        chk("err_set", bus.err_rw, 1);
        chk("err_entry_valid", bus.mem_valid, 1);
        chk("err_entry_data", bus.mem_data, 32'h77);
        chk("err_entry_re", bus.mem_mem_re, 1);
        chk("err_entry_we", bus.mem_mem_we, 1);
        chk("err_entry_size", bus.mem_mem_size, 3);
        idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("err_after_flush", bus.err_rw, 1);
        chk("err_flush_valid", bus.mem_valid, 0);

        // asynchronous reset mid-stream with both entries full
        bus.mem_ready = 1'b0;
        send(32'hC1);
        step();
        send(32'hC2);
        step();
        chk("mid_full_ready", bus.ex_ready, 0);
        chk("mid_full_valid", bus.mem_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", bus.mem_valid, 0);
        chk("mid_rst_ready", bus.ex_ready, 1);
        chk("mid_rst_data", bus.mem_data, 0);
        chk("mid_rst_addr", bus.mem_mem_addr, 0);
        chk("mid_rst_err", bus.err_rw, 0);
        idle();
        bus.mem_ready = 1'b1;
        step();
        rst = 1'b1;
        step();
        chk("mid_release_valid", bus.mem_valid, 0);
        step();
        chk("mid_release_valid2", bus.mem_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
